// File: rtl/uart_pkg.sv
// Shared register map, CON bit layout and TX sequencer states for the UART MMIO block.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [31:0] TXD_OFS = 32'h0000_0000;
    localparam logic [31:0] RXD_OFS = 32'h0000_0004;
    localparam logic [31:0] CON_OFS = 32'h0000_0008;

    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_RX_NONEMPT = 2;
    localparam int CON_TX_DONE    = 3;
    localparam int CON_HOLD_FULL  = 4;
    localparam int CON_RX_OVF     = 5;
    localparam int CON_TX_BUSY    = 6;
    localparam int CON_TX_OVF     = 7;
    localparam int CON_CNT_LO     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; a push into a full FIFO only succeeds when a pop frees the head slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_drop
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    logic [BYTE_W-1:0] r_mem [RX_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(RX_DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // NOTE: storage has no reset; occupancy is tracked by r_count, so stale entries are never visible.
    always_ff @(posedge sysclk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-side register front end for the UART cores: TXD/RXD/CON decode, RX buffering, TX sequencing and IRQ.
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
    parameter int          RX_DEPTH  = 4,
    parameter int          CNT_W     = 3
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        irq
);

    tx_state_t   r_state;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_hold_full;
    logic [7:0]  r_hold_byte;
    logic        r_tx_irq_en;
    logic        r_rx_irq_en;
    logic        r_tx_done;
    logic        r_rx_ovf;
    logic        r_tx_ovf;
    logic        r_irq;

    logic             w_sel_txd;
    logic             w_sel_rxd;
    logic             w_sel_con;
    logic             w_wr_txd;
    logic             w_wr_con;
    logic             w_rd_con;
    logic             w_pop;
    logic [7:0]       w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_rx_drop;
    logic             w_tx_done_set;
    logic [31:0]      w_con;
    logic             w_unused_wdata;

    assign w_sel_txd     = (addr == BASE_ADDR + TXD_OFS);
    assign w_sel_rxd     = (addr == BASE_ADDR + RXD_OFS);
    assign w_sel_con     = (addr == BASE_ADDR + CON_OFS);
    assign w_wr_txd      = mem_wr & w_sel_txd;
    assign w_wr_con      = mem_wr & w_sel_con;
    assign w_rd_con      = mem_rd & w_sel_con;
    assign w_pop         = mem_rd & w_sel_rxd & ~w_empty;
    assign w_tx_done_set = (r_state == WAIT_LO) & ~tx_busy;
    assign w_unused_wdata = &{1'b0, wdata[31:8]};

    uart_rx_fifo #(
        .RX_DEPTH (RX_DEPTH),
        .CNT_W    (CNT_W)
    ) u_rx_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .i_push  (rx_valid),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_rx_drop)
    );

    always_comb begin
        w_con                           = '0;
        w_con[CON_TX_IRQ_EN]            = r_tx_irq_en;
        w_con[CON_RX_IRQ_EN]            = r_rx_irq_en;
        w_con[CON_RX_NONEMPT]           = ~w_empty;
        w_con[CON_TX_DONE]              = r_tx_done;
        w_con[CON_HOLD_FULL]            = r_hold_full;
        w_con[CON_RX_OVF]               = r_rx_ovf;
        w_con[CON_TX_BUSY]              = tx_busy;
        w_con[CON_TX_OVF]               = r_tx_ovf;
        w_con[CON_CNT_LO +: CNT_W]      = w_count;
    end

    // NOTE: rdata gets a default before any branch so no path leaves it unassigned and infers a latch.
    always_comb begin
        rdata = '0;
        if (mem_rd) begin
            if (w_sel_txd)      rdata = {24'b0, r_hold_byte};
            else if (w_sel_rxd) rdata = w_empty ? 32'b0 : {24'b0, w_head};
            else if (w_sel_con) rdata = w_con;
        end
    end

    // CPU-visible control/status; a set event in the same cycle as a CON read keeps the sticky bit high.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tx_irq_en <= 1'b0;
            r_rx_irq_en <= 1'b0;
            r_tx_done   <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_byte <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_tx_irq_en <= wdata[CON_TX_IRQ_EN];
                r_rx_irq_en <= wdata[CON_RX_IRQ_EN];
            end
            r_tx_done <= w_tx_done_set | (r_tx_done & ~w_rd_con);
            r_rx_ovf  <= w_rx_drop     | (r_rx_ovf  & ~w_rd_con);
            r_tx_ovf  <= (w_wr_txd & r_hold_full) | (r_tx_ovf & ~w_rd_con);

            // START always sees a full holding register, so a load and a release never coincide.
            if (w_wr_txd && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_byte <= wdata[7:0];
            end else if (r_state == START) begin
                r_hold_full <= 1'b0;
            end

            r_irq <= (r_tx_irq_en & r_tx_done) | (r_rx_irq_en & ~w_empty);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_hold_full) begin
                        r_state    <= START;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_hold_byte;
                    end
                end
                START:   r_state <= WAIT_HI;
                WAIT_HI: if (tx_busy)  r_state <= WAIT_LO;
                WAIT_LO: if (!tx_busy) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign irq      = r_irq;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed scoreboard bench for uart_mmio_ctrl: RX bytes and TX bytes are queued as driven and checked as produced.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] rdata;
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy  = 1'b0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tx_starts = 0;

    logic [7:0] rx_sb[$];
    logic [7:0] tx_sb[$];

    uart_mmio_ctrl #(
        .BASE_ADDR (BASE),
        .RX_DEPTH  (4),
        .CNT_W     (3)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .irq      (irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each transmitted byte is compared against the oldest accepted TXD write.
    always @(negedge sysclk) begin
        if (!reset && tx_start === 1'b1) begin
            n_tx_starts++;
            if (tx_sb.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
            else                   check("tx_data", {24'b0, tx_data}, {24'b0, tx_sb.pop_front()});
        end
    end

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge sysclk);
        mem_rd = 1'b1;
        addr   = a;
        #1 d = rdata;
        @(posedge sysclk);
        #1 mem_rd = 1'b0;
        addr = '0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        mem_wr = 1'b1;
        addr   = a;
        wdata  = d;
        @(posedge sysclk);
        #1 mem_wr = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic rxd_check(input string tag);
        logic [31:0] exp;
        exp = (rx_sb.size() == 0) ? 32'd0 : {24'b0, rx_sb.pop_front()};
        read_check(tag, RXD, exp);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge sysclk);
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_sb.size() < 4) rx_sb.push_back(b);
        @(posedge sysclk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_tx_start(output int n, output logic found);
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(negedge sysclk);
            n++;
            if (tx_start === 1'b1) found = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        logic        found;

        // Reset state
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        read_check("reset_con", CON, 32'd0);
        repeat (3) @(negedge sysclk);
        check("reset_no_tx_start", 32'(n_tx_starts), 32'd0);

        // Two RX bytes, ordered reads, then empty read
        rx_push(8'h55);
        rx_push(8'hFF);
        read_check("rx2_con", CON, 32'h0000_0204);
        read_check("bad_addr_read", BASE + 32'd12, 32'd0);
        rxd_check("rx_first");
        rxd_check("rx_second");
        rxd_check("rx_empty_read");
        read_check("rx_empty_con", CON, 32'd0);

        // Overflow on the fifth push, sticky clear on CON read
        for (int i = 1; i <= 5; i++) rx_push(8'(i));
        read_check("rx_ovf_con", CON, 32'h0000_0424);
        read_check("rx_ovf_cleared", CON, 32'h0000_0404);

        // Push and pop together while full
        @(negedge sysclk);
        rx_valid = 1'b1;
        rx_data  = 8'h06;
        mem_rd   = 1'b1;
        addr     = RXD;
        #1 d = rdata;
        @(posedge sysclk);
        #1 rx_valid = 1'b0;
        mem_rd = 1'b0;
        addr   = '0;
        check("full_push_pop_data", d, {24'b0, rx_sb.pop_front()});
        rx_sb.push_back(8'h06);
        read_check("full_push_pop_con", CON, 32'h0000_0404);
        for (int i = 0; i < 4; i++) rxd_check("rx_drain");
        read_check("rx_drained_con", CON, 32'd0);

        // Single TX byte with interrupt
        cpu_write(CON, 32'h1);
        tx_sb.push_back(8'hFA);
        cpu_write(TXD, 32'h0000_00FA);
        wait_tx_start(n, found);
        check("tx_start_latency", 32'(n), 32'd2);
        tx_busy = 1'b1;
        repeat (10) @(negedge sysclk);
        tx_busy = 1'b0;
        @(negedge sysclk);
        check("irq_not_yet", {31'b0, irq}, 32'd0);
        @(negedge sysclk);
        check("irq_raised", {31'b0, irq}, 32'd1);
        read_check("tx_done_con", CON, 32'h0000_0009);
        @(posedge sysclk);
        #1 check("irq_cleared", {31'b0, irq}, 32'd0);
        read_check("tx_done_cleared", CON, 32'h0000_0001);

        // Queued bytes and a dropped third write
        cpu_write(CON, 32'h0);
        tx_sb.push_back(8'hC6);
        cpu_write(TXD, 32'h0000_00C6);
        wait_tx_start(n, found);
        check("tx_c6_seen", {31'b0, found}, 32'd1);
        tx_sb.push_back(8'h11);
        cpu_write(TXD, 32'h0000_0011);
        cpu_write(TXD, 32'h0000_0022);
        read_check("tx_ovf_con", CON, 32'h0000_0090);
        read_check("txd_readback", TXD, 32'h0000_0011);
        read_check("partial_addr_read", 32'h5000_0018, 32'd0);
        @(negedge sysclk);
        tx_busy = 1'b1;
        repeat (3) @(negedge sysclk);
        tx_busy = 1'b0;
        wait_tx_start(n, found);
        check("tx_11_seen", {31'b0, found}, 32'd1);
        tx_busy = 1'b1;
        repeat (3) @(negedge sysclk);
        tx_busy = 1'b0;
        repeat (3) @(negedge sysclk);

        // Reset in WAIT_LO with a byte held
        tx_sb.push_back(8'h33);
        cpu_write(TXD, 32'h0000_0033);
        wait_tx_start(n, found);
        check("tx_33_seen", {31'b0, found}, 32'd1);
        tx_busy = 1'b1;
        repeat (2) @(negedge sysclk);
        cpu_write(TXD, 32'h0000_0044);
        read_check("wait_lo_hold_con", CON, 32'h0000_0058);
        @(negedge sysclk);
        reset   = 1'b1;
        tx_busy = 1'b0;
        #1;
        check("rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        read_check("rst_con", CON, 32'd0);
        read_check("rst_txd", TXD, 32'd0);
        @(negedge sysclk);
        reset = 1'b0;
        repeat (10) @(negedge sysclk);
        check("tx_start_total", 32'(n_tx_starts), 32'd4);
        check("tx_sb_empty", 32'(tx_sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped controller between the pipelined CPU's data-memory bus and the byte-level UART receiver/transmitter cores.
- Decodes three peripheral registers, buffers received bytes in a small RX FIFO, and holds one pending TX byte.
- Sequences each TX byte through a start/busy handshake with the transmitter and raises a level interrupt request toward the CPU.
- Instantiated beside the UART cores inside CPU_P, clocked by sysclk.

Parameters:
- BASE_ADDR, 32'h4000_0018, byte address of UART_TXD; UART_RXD is BASE_ADDR+4, UART_CON is BASE_ADDR+8.
- RX_DEPTH, 4, RX FIFO entries; must be a power of two, at least 2.
- CNT_W, 3, width of the RX occupancy count; equals log2(RX_DEPTH)+1.

Ports:
- sysclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state.
- mem_rd  in  1  CPU data read strobe.
- mem_wr  in  1  CPU data write strobe.
- addr  in  32  CPU byte address.
- wdata  in  32  CPU write data.
- rdata  out  32  read data; combinational, valid in the same cycle as mem_rd.
- rx_data  in  8  byte from the receiver.
- rx_valid  in  1  one-cycle pulse from the receiver: rx_data is valid.
- tx_data  out  8  byte to the transmitter.
- tx_start  out  1  one-cycle pulse: transmitter latches tx_data.
- tx_busy  in  1  transmitter is shifting a frame.
- irq  out  1  level interrupt request.

Behaviour:
- Reset values: rdata 0, tx_data 0, tx_start 0, irq 0. FIFO empty, TX holding register empty, all CON bits 0, FSM in IDLE.
- Address decode compares the full 32 bits. A strobe at any non-matching address is ignored and rdata is 0.
- UART_TXD write (wdata[7:0]):
  - Holding register empty: the byte loads and hold_full is set.
  - Holding register full: the write is dropped and sticky tx_ovf is set.
  - Reading UART_TXD returns {24'b0, last held byte}.
- UART_RXD read:
  - FIFO non-empty: rdata = {24'b0, head}, and the head pops at the clock edge.
  - FIFO empty: rdata 0, no state change.
- UART_CON read/write layout:
  - [0] tx_irq_en: R/W.
  - [1] rx_irq_en: R/W.
  - [2] rx_nonempty: RO.
  - [3] tx_done: sticky; cleared by a UART_CON read.
  - [4] hold_full: RO.
  - [5] rx_ovf: sticky; cleared by a UART_CON read.
  - [6] tx_busy: RO, mirrors the input.
  - [7] tx_ovf: sticky; cleared by a UART_CON read.
  - [10:8] rx count: RO.
  - All other bits read 0.
  - Writes affect bits [1:0] only.
  - If a set event and a clearing read land in the same cycle, the set wins.
- RX push on rx_valid:
  - FIFO not full: the byte is written at the tail.
  - FIFO full with no pop that cycle: the byte is dropped and rx_ovf is set.
  - Full, with push and pop in the same cycle: both happen, count unchanged, no overflow.
  - Pointers wrap modulo RX_DEPTH.
- TX FSM:
  - IDLE: when hold_full, go to START.
  - START: tx_start=1 for exactly one cycle, tx_data = held byte. Clear hold_full, go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for tx_busy=0, then set tx_done and go to IDLE.
  - A new TXD write is accepted while the FSM is in WAIT_*, because the holding register was freed at START. Back-to-back bytes therefore queue with a gap of 2 cycles.
  - Latency from TXD write to tx_start is 2 cycles: load, then the START state.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_nonempty), registered with 1-cycle latency.
- Reset asserted mid-frame: the FSM returns to IDLE and tx_start stays 0. The held byte and FIFO contents are discarded.

Decomposition:
- Shared package uart_pkg:
  - register offset constants TXD_OFS/RXD_OFS/CON_OFS;
  - CON bit-index constants;
  - the TX FSM state enum {IDLE, START, WAIT_HI, WAIT_LO}.
- One sub-module, uart_rx_fifo:
  - parameters RX_DEPTH and CNT_W;
  - synchronous push/pop with simultaneous-access rules as above;
  - outputs head, count, empty, full.

Test Plan:
- Reset then a UART_CON read: rdata=0, irq=0, tx_start never pulses.
- rx_valid with 0x55, then with 0xFF; read UART_CON: [2]=1, [10:8]=2. Read RXD twice: 0x55, then 0xFF. A third read returns 0 and [2]=0.
- Five rx_valid pushes (0x01..0x05) without pops: the FIFO holds 0x01..0x04 and rx_ovf=1. A CON read clears rx_ovf. Then push plus pop in the same cycle while full: count stays 4, rx_ovf stays 0.
- Write TXD 0xFA: tx_start pulses 2 cycles later with tx_data=0xFA. Model tx_busy high for 10 cycles: tx_done=1 after the fall. With tx_irq_en=1, irq rises one cycle later; a CON read clears it.
- Write TXD 0xC6 then 0x11 during WAIT_HI, then 0x22 while hold_full: 0x22 is dropped and tx_ovf=1. 0xC6 and 0x11 are each sent with a tx_start pulse.
- Assert reset while in WAIT_LO with hold_full=1: all outputs return to 0, and no tx_start follows after release.
